// File: rtl/mast_piso_slave_data.sv
// I2C master transmit shifter: accepts one byte, shifts it MSB-first onto SDA, then samples the slave ACK.
// Optional MAST_TX_NACK_ERR_EN adds master_tx_nack_err and one extra not-ready cycle after DONE.
module mast_piso_slave_data #(
    parameter int DATA_WIDTH  = 8,
    parameter int BIT_TICKS   = 16,
    parameter int SAMPLE_TICK = 8
) (
    input  logic                  master_scl_sixt,
    input  logic                  master_rst_n,
    input  logic [DATA_WIDTH-1:0] master_tx_data,
    input  logic                  master_tx_valid,
    output logic                  master_tx_ready,
    input  logic                  master_sda_in,
    output logic                  master_sda_out,
    output logic                  master_sda_oe,
    output logic                  master_tx_busy,
    output logic                  master_tx_done,
    output logic                  master_tx_ack,
`ifdef MAST_TX_NACK_ERR_EN
    output logic                  master_tx_nack_err,
`endif
    output logic [1:0]            master_tx_state
);

    localparam int TICK_W = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_SMPL = TICK_W'(SAMPLE_TICK);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    // Handshake: a byte is taken at a rising edge where master_tx_valid and
    // master_tx_ready are both high; ready is decoded from state, valid is not
    // buffered, and master_tx_data is only looked at on that edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    logic                  hold_q;
    logic                  accept;

    assign shift_next      = shift_q << 1;
    assign master_tx_ready = (state == IDLE) && !hold_q;
    assign accept          = master_tx_valid && master_tx_ready;
    assign master_tx_state = state;

`ifdef MAST_TX_NACK_ERR_EN
    logic ack_sample;
    // Covers SAMPLE_TICK == BIT_TICKS-1, where the sample and the DONE entry share an edge.
    assign ack_sample = (tick_cnt == TICK_SMPL) ? ~master_sda_in : master_tx_ack;
`else
    assign hold_q = 1'b0;
`endif

    always_ff @(posedge master_scl_sixt) begin
        if (!master_rst_n) begin
            state          <= IDLE;
            shift_q        <= '0;
            bit_cnt        <= '0;
            tick_cnt       <= '0;
            master_sda_out <= 1'b1;
            master_sda_oe  <= 1'b0;
            master_tx_busy <= 1'b0;
            master_tx_done <= 1'b0;
            master_tx_ack  <= 1'b0;
`ifdef MAST_TX_NACK_ERR_EN
            master_tx_nack_err <= 1'b0;
            hold_q             <= 1'b0;
`endif
        end else begin
            master_tx_done <= 1'b0;
`ifdef MAST_TX_NACK_ERR_EN
            master_tx_nack_err <= 1'b0;
            hold_q             <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    master_sda_oe  <= 1'b0;
                    master_sda_out <= 1'b1;
                    master_tx_busy <= 1'b0;
                    if (accept) begin
                        shift_q        <= master_tx_data;
                        bit_cnt        <= BIT_LAST;
                        tick_cnt       <= '0;
                        master_tx_ack  <= 1'b0;
                        master_sda_oe  <= 1'b1;
                        master_sda_out <= master_tx_data[DATA_WIDTH-1];
                        master_tx_busy <= 1'b1;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (bit_cnt == '0) begin
                            master_sda_oe  <= 1'b0;
                            master_sda_out <= 1'b1;
                            state          <= ACK;
                        end else begin
                            shift_q        <= shift_next;
                            master_sda_out <= shift_next[DATA_WIDTH-1];
                            bit_cnt        <= bit_cnt - BIT_W'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                ACK: begin
                    // SDA low at the sample tick means the slave acknowledged.
                    if (tick_cnt == TICK_SMPL) begin
                        master_tx_ack <= ~master_sda_in;
                    end
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt       <= '0;
                        master_tx_done <= 1'b1;
                        state          <= DONE;
`ifdef MAST_TX_NACK_ERR_EN
                        master_tx_nack_err <= ~ack_sample;
`endif
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                DONE: begin
                    master_tx_busy <= 1'b0;
                    state          <= IDLE;
`ifdef MAST_TX_NACK_ERR_EN
                    hold_q <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mast_piso_slave_data.sv
// Directed bench for mast_piso_slave_data: per-cycle SDA/handshake checks against hand-derived values.
// Build with +define+MAST_TX_NACK_ERR_EN to also cover the NACK error output.
module tb_mast_piso_slave_data;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sda_in;
  logic       sda_out;
  logic       sda_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack;
  logic [1:0] dbg_state;
`ifdef MAST_TX_NACK_ERR_EN
  logic       nack_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  mast_piso_slave_data dut (
    .master_scl_sixt    (clk),
    .master_rst_n       (rst_n),
    .master_tx_data     (tx_data),
    .master_tx_valid    (tx_valid),
    .master_tx_ready    (tx_ready),
    .master_sda_in      (sda_in),
    .master_sda_out     (sda_out),
    .master_sda_oe      (sda_oe),
    .master_tx_busy     (tx_busy),
    .master_tx_done     (tx_done),
    .master_tx_ack      (tx_ack),
`ifdef MAST_TX_NACK_ERR_EN
    .master_tx_nack_err (nack_err),
`endif
    .master_tx_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Leaves the bench just after the accept edge E0.
  task automatic accept(input logic [7:0] d);
    bit got = 1'b0;
    tx_valid = 1'b1;
    tx_data  = d;
    for (int i = 0; i < 300 && !got; i++) begin
      if (tx_ready) got = 1'b1;
      step();
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    tx_valid = 1'b0;
  endtask

  // Starts just after E0; ends where ready has come back high.
  task automatic run_byte(input logic [7:0] d, input bit ack_low, input bit hold_valid,
                          input logic [7:0] next_d);
    sda_in = ack_low;  // opposite of the ACK-slot level: must be ignored while shifting
    for (int s = 0; s < 8; s++) begin
      for (int t = 0; t < 16; t++) begin
        check("shift", {sda_oe, sda_out, tx_busy, tx_ready, tx_done, dbg_state},
              {1'b1, d[7-s], 1'b1, 1'b0, 1'b0, 2'd1});
        if (hold_valid) begin
          tx_valid = 1'b1;
          tx_data  = next_d;
        end else begin
          tx_valid = 1'($urandom_range(0, 1));
          tx_data  = 8'($urandom_range(0, 255));
        end
        step();
      end
    end
    sda_in = ack_low ? 1'b0 : 1'b1;
    for (int t = 0; t < 16; t++) begin
      check("ack_slot", {sda_oe, sda_out, tx_busy, tx_ready, tx_done},
            {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      step();
    end
    tx_valid = hold_valid;
    sda_in   = 1'b1;
    check("done", {tx_done, tx_busy, tx_ready, tx_ack}, {1'b1, 1'b1, 1'b0, ack_low});
`ifdef MAST_TX_NACK_ERR_EN
    check("nack_err", nack_err, !ack_low);
`endif
    step();
    check("after_done", {tx_done, tx_busy, tx_ack}, {1'b0, 1'b0, ack_low});
`ifdef MAST_TX_NACK_ERR_EN
    check("nack_err_clr", nack_err, 1'b0);
    check("ready_held", tx_ready, 1'b0);
    step();
`endif
    check("ready_back", {tx_ready, tx_ack}, {1'b1, ack_low});
  endtask

  initial begin
    bit seen_done;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    sda_in   = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_out", {sda_oe, sda_out, tx_done, tx_ack, tx_busy, tx_ready},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    step();
    check("idle_ready", {tx_ready, sda_oe}, {1'b1, 1'b0});

    // 0xA5 acknowledged
    accept(8'hA5);
    run_byte(8'hA5, 1'b1, 1'b0, 8'h00);

    // 0x3C with SDA left high: NACK
    accept(8'h3C);
    run_byte(8'h3C, 1'b0, 1'b0, 8'h00);

    // Back-to-back: valid held, 0xFF (ack) then 0x00 (nack)
    accept(8'hFF);
    run_byte(8'hFF, 1'b1, 1'b1, 8'h00);
    step();
    check("b2b_accept", {sda_oe, sda_out, tx_ack, tx_busy}, {1'b1, 1'b0, 1'b0, 1'b1});
    tx_valid = 1'b0;
    run_byte(8'h00, 1'b0, 1'b0, 8'h00);

    // Reset at cycle 50 of a transfer
    accept(8'h81);
    for (int i = 0; i < 49; i++) step();
    check("pre_rst_busy", {tx_busy, sda_oe}, {1'b1, 1'b1});
    rst_n = 1'b0;
    step();
    check("mid_rst", {sda_oe, sda_out, tx_busy, tx_done, tx_ack, tx_ready},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_done) seen_done = 1'b1;
      step();
    end
    check("no_done_after_rst", seen_done, 1'b0);

    // Normal transfer after the abort
    accept(8'h5A);
    run_byte(8'h5A, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
